// File: rtl/bitonic_pkg.sv
// bitonic_pkg: shared types and constants for the bitonic sorter front end.
package bitonic_pkg;
  typedef enum logic {FILL, FULL} state_e;
  localparam int DATALENGTH_DEF = 32;
  localparam int CNT_W = $clog2(DATALENGTH_DEF);
endpackage

// File: rtl/bitonic_valid_pipe.sv
// bitonic_valid_pipe: WIDTH x DEPTH delay line with async active-low reset.
module bitonic_valid_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/bitonic_feeder.sv
// bitonic_feeder: packs a scalar stream into padded vectors for a bitonic sorter.
// Define BITONIC_FEEDER_STATS_EN to add vec_cnt_o / pad_cnt_o statistics ports.
module bitonic_feeder
  import bitonic_pkg::*;
#(
  parameter int                  DATAWIDTH    = 8,
  parameter int                  DATALENGTH   = 32,
  parameter int                  SORT_LATENCY = 5,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DATAWIDTH-1:0] s_data_i,
  input  logic                 s_last_i,
  input  logic                 sign_ctrl_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATAWIDTH-1:0] x_o [DATALENGTH],
  output logic                 sign_ctrl_o,
  output logic                 m_last_o,
`ifdef BITONIC_FEEDER_STATS_EN
  output logic [31:0]          vec_cnt_o,
  output logic [31:0]          pad_cnt_o,
`endif
  output logic                 sorted_valid_o,
  output logic                 sorted_last_o
);
  localparam int CW = $clog2(DATALENGTH);
  logic [DATAWIDTH-1:0] acc [DATALENGTH];
  logic [DATAWIDTH-1:0] acc_d [DATALENGTH];
  logic acc_sign, acc_sign_d, acc_last;
  logic [CW-1:0] cnt;
  state_e state, state_d;
  logic accept, done, drain, out_free, load_direct, load_held;
  assign s_ready_o   = state == FILL;
  assign accept      = s_valid_i & s_ready_o;
  assign done        = accept & (cnt == CW'(DATALENGTH-1) | s_last_i);
  assign drain       = m_valid_o & m_ready_i;
  assign out_free    = !m_valid_o | m_ready_i;
  assign load_direct = done & out_free;
  assign load_held   = state == FULL & m_ready_i;
  always_comb begin
    state_d = state == FILL ? ((done & !out_free) ? FULL : FILL) : (m_ready_i ? FILL : FULL);
  end
  // Next accumulator image; on completion lanes beyond the current one become padding
  always_comb begin
    for (int i = 0; i < DATALENGTH; i++)
      acc_d[i] = (accept & CW'(i) == cnt) ? s_data_i :
                 (done & CW'(i) > cnt) ? PAD_VALUE : acc[i];
    acc_sign_d = (accept & cnt == '0) ? sign_ctrl_i : acc_sign;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state    <= FILL;
      cnt      <= '0;
      acc_sign <= 1'b0;
      acc_last <= 1'b0;
      for (int i = 0; i < DATALENGTH; i++) acc[i] <= PAD_VALUE;
    end else begin
      state <= state_d;
      if (accept) begin
        acc      <= acc_d;
        acc_sign <= acc_sign_d;
        acc_last <= s_last_i;
        cnt      <= done ? '0 : cnt + 1'b1;
      end
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      m_valid_o   <= 1'b0;
      m_last_o    <= 1'b0;
      sign_ctrl_o <= 1'b0;
      for (int i = 0; i < DATALENGTH; i++) x_o[i] <= PAD_VALUE;
    end else if (load_direct) begin
      m_valid_o   <= 1'b1;
      m_last_o    <= s_last_i;
      sign_ctrl_o <= acc_sign_d;
      x_o         <= acc_d;
    end else if (load_held) begin
      m_valid_o   <= 1'b1;
      m_last_o    <= acc_last;
      sign_ctrl_o <= acc_sign;
      x_o         <= acc;
    end else if (drain)
      m_valid_o <= 1'b0;
  bitonic_valid_pipe #(.WIDTH(2), .DEPTH(SORT_LATENCY)) u_track (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .d     ({drain, m_last_o & drain}),
    .q     ({sorted_valid_o, sorted_last_o})
  );
`ifdef BITONIC_FEEDER_STATS_EN
  logic [32:0] pad_sum;
  assign pad_sum = {1'b0, pad_cnt_o} + 33'(DATALENGTH - 1) - 33'(cnt);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      vec_cnt_o <= '0;
      pad_cnt_o <= '0;
    end else begin
      if (drain) vec_cnt_o <= vec_cnt_o + 1'b1;
      if (done) pad_cnt_o <= pad_sum[32] ? '1 : pad_sum[31:0];
    end
`endif
endmodule
